morse_decoder: RTL and testbench
================================

# morse_decoder

Receive-side counterpart of the lab2 Morse transmitter. It samples the keyed serial line, times each mark and space against a configurable unit length, and classifies marks as dots or dashes. It assembles up to four elements per character and decodes the alphabet A–H into the same 3-bit letter code the transmitter takes on its switches. Its intended placement is on the board directly after the transmitter's keyed output (loopback), with the letter driving LEDs or a 7-segment display.

## Interface
- `UNIT`, default 25_000_000: clock cycles per Morse time unit (0.5 s at 50 MHz). The bench overrides it to 4.
- `clk`, in, 1: system clock; all logic runs on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `key_in`, in, 1: keyed line; 1 = mark (tone on). Asynchronous to `clk`.
- `valid`, out, 1: one-cycle pulse when a character is decoded.
- `err`, out, 1: one-cycle pulse when a character is rejected.
- `letter`, out, 3: decoded letter, 0=A … 7=H. Holds until the next `valid`.
- `sym_len`, out, 3: element count of the last decoded character (1–4). Holds until the next `valid`.
- `sym_bits`, out, 4: element pattern, right-aligned. 1 = dash; the first element is in bit `sym_len-1`. Holds until the next `valid`.
- `busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- `key_in` passes through a 2-FF synchronizer; all timing uses the synchronized value `ks`.
- Duration counter:
  - Counts consecutive cycles of the current `ks` level.
  - Width is `$clog2(6*UNIT+1)`.
  - Saturates at `6*UNIT`.
- FSM states:
  - **IDLE**: `ks`=0, element buffer empty. `ks` rising → MARK, counter = 1.
  - **MARK**: counting the high time L.
    - On `ks` falling, classify: dot if L < 2*UNIT; dash if 2*UNIT ≤ L < 6*UNIT.
    - Shift the element into the buffer (shift left, insert at LSB), increment the count, go to SPACE with counter = 1.
    - If the buffer already holds 4 elements, set the internal overflow flag instead of shifting.
    - If L reaches 6*UNIT while `ks` is still high → pulse `err`, clear the buffer, go to WAIT_LOW.
  - **SPACE**: counting the low time S.
    - `ks` rising while S < 2*UNIT → back to MARK (same character).
    - S reaching 2*UNIT → DECODE.
  - **DECODE** (1 cycle), look up (count, pattern):
    - A=(2,01), B=(4,1000), C=(4,1010), D=(3,100), E=(1,0), F=(4,0010), G=(3,110), H=(4,0000).
    - Match and no overflow → register `letter`/`sym_len`/`sym_bits` and pulse `valid`.
    - Otherwise → pulse `err`; outputs keep their previous values.
    - Clear the buffer and overflow flag. Go to IDLE, or to MARK (counter = 1) if `ks` is already high.
  - **WAIT_LOW**: remain until `ks`=0, then go to IDLE. No further `err` pulses while stuck high.
- `valid` and `err` are never high in the same cycle.

## Timing
- Reset (async, `rst`=0), all outputs and internal state clear immediately:
  - `valid`=0, `err`=0, `letter`=0, `sym_len`=0, `sym_bits`=0, `busy`=0.
  - FSM = IDLE; synchronizer, counter, buffer and overflow flag cleared.
- Reset asserted mid-character discards the partial character. After release, no `valid` or `err` is produced for it.
- `ks` lags `key_in` by 2 clocks. Mark and space lengths measured on `ks` equal the `key_in` lengths in cycles.
- Latency: `valid`/`err` asserts on the clock edge 2*UNIT+3 cycles after the first edge that samples `key_in`=0 following the last mark. It stays high exactly 1 cycle.
- `letter`, `sym_len` and `sym_bits` update on the same edge that asserts `valid`.
- Stuck-high `err` asserts 6*UNIT+2 cycles after the first edge that samples `key_in`=1.
- Class boundaries are exact:
  - L = 2*UNIT−1 → dot; L = 2*UNIT → dash.
  - S = 2*UNIT−1 → same character; S = 2*UNIT → end of character.
- `busy` is high from the first cycle in MARK through the DECODE cycle and throughout WAIT_LOW.

## Test plan
All scenarios use `UNIT`=4.
- Reset: drive `key_in`=1 for 6 cycles, assert `rst`=0 for 3 cycles, release, drive `key_in`=0 for 20 cycles → all outputs 0 throughout; no `valid`/`err`.
- Letter A: high 4, low 4, high 12, low 10 → one `valid` pulse 11 cycles after the falling edge; `letter`=0, `sym_len`=2, `sym_bits`=4'b0001; `busy` returns to 0.
- Full alphabet A–H sent with dot=4, dash=12, element gap 4, character gap 12 → eight `valid` pulses with `letter` 0,1,…,7; `sym_bits` = 0001, 1000, 1010, 0100, 0000, 0010, 0110, 0000.
- Boundaries:
  - Single mark of 7 cycles then low 8 → E (`letter`=4).
  - Mark of 8 cycles → dash alone → `err` (pattern (1,1) is T, unmatched).
  - Dot, low 7, dot, low 8 → one character with `sym_len`=2 (I → `err`).
- Errors:
  - Five dots with 4-cycle gaps → single `err`, no `valid`.
  - `key_in` held high 40 cycles → `err` once, exactly 26 cycles after rise; after release the next A decodes correctly.
- Hold: after decoding G, send an unmatched "---" → `err`; `letter` stays 6 and `sym_bits` stays 0110.

Source files
------------

// File: rtl/morse_decoder.sv
// morse_decoder: times marks/spaces on a keyed line, classifies dots/dashes
// and decodes the letters A-H into a 3-bit code.
module morse_decoder #(
    parameter int UNIT = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       valid,
    output logic       err,
    output logic [2:0] letter,
    output logic [2:0] sym_len,
    output logic [3:0] sym_bits,
    output logic       busy
);
    localparam int CW = $clog2(6*UNIT+1);
    localparam logic [CW-1:0] C_MAX  = CW'(6*UNIT);
    localparam logic [CW-1:0] C_DASH = CW'(2*UNIT);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [2:0] {S_IDLE, S_MARK, S_SPACE, S_DECODE, S_WAIT} state_t;

    state_t          r_state, w_next;
    logic            r_sync1, r_ks;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [3:0]      r_buf, w_buf;
    logic [2:0]      r_n, w_n;
    logic            r_ovf, w_ovf;
    logic            r_valid, w_valid, r_err, w_err;
    logic [2:0]      r_letter, w_letter, r_len, w_len;
    logic [3:0]      r_bits, w_bits;
    logic            w_hit;
    logic [2:0]      w_code;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_sync1  <= 1'b0;
            r_ks     <= 1'b0;
            r_cnt    <= '0;
            r_buf    <= '0;
            r_n      <= '0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_letter <= '0;
            r_len    <= '0;
            r_bits   <= '0;
        end else begin
            r_state  <= w_next;
            r_sync1  <= key_in;
            r_ks     <= r_sync1;
            r_cnt    <= w_cnt;
            r_buf    <= w_buf;
            r_n      <= w_n;
            r_ovf    <= w_ovf;
            r_valid  <= w_valid;
            r_err    <= w_err;
            r_letter <= w_letter;
            r_len    <= w_len;
            r_bits   <= w_bits;
        end
    end

    // Upper buffer bits stay zero, so the raw {count, buffer} is the lookup key.
    always_comb begin
        w_hit  = 1'b1;
        w_code = 3'd0;
        case ({r_n, r_buf})
            7'b010_0001: w_code = 3'd0;
            7'b100_1000: w_code = 3'd1;
            7'b100_1010: w_code = 3'd2;
            7'b011_0100: w_code = 3'd3;
            7'b001_0000: w_code = 3'd4;
            7'b100_0010: w_code = 3'd5;
            7'b011_0110: w_code = 3'd6;
            7'b100_0000: w_code = 3'd7;
            default:     w_hit  = 1'b0;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_cnt    = (r_cnt == C_MAX) ? r_cnt : r_cnt + C_ONE;
        w_buf    = r_buf;
        w_n      = r_n;
        w_ovf    = r_ovf;
        w_valid  = 1'b0;
        w_err    = 1'b0;
        w_letter = r_letter;
        w_len    = r_len;
        w_bits   = r_bits;
        case (r_state)
            S_IDLE: begin
                if (r_ks) begin
                    w_next = S_MARK;
                    w_cnt  = C_ONE;
                end
            end
            S_MARK: begin
                if (r_cnt == C_MAX) begin
                    w_err  = 1'b1;
                    w_buf  = '0;
                    w_n    = '0;
                    w_ovf  = 1'b0;
                    w_next = S_WAIT;
                end else if (!r_ks) begin
                    w_ovf  = r_ovf | (r_n == 3'd4);
                    w_buf  = (r_n == 3'd4) ? r_buf : {r_buf[2:0], r_cnt >= C_DASH};
                    w_n    = (r_n == 3'd4) ? r_n : r_n + 3'd1;
                    w_next = S_SPACE;
                    w_cnt  = C_ONE;
                end
            end
            S_SPACE: begin
                if (r_cnt == C_DASH) begin
                    w_next = S_DECODE;
                end else if (r_ks) begin
                    w_next = S_MARK;
                    w_cnt  = C_ONE;
                end
            end
            S_DECODE: begin
                w_valid  = w_hit & ~r_ovf;
                w_err    = ~(w_hit & ~r_ovf);
                w_letter = w_valid ? w_code : r_letter;
                w_len    = w_valid ? r_n : r_len;
                w_bits   = w_valid ? r_buf : r_bits;
                w_buf    = '0;
                w_n      = '0;
                w_ovf    = 1'b0;
                w_next   = r_ks ? S_MARK : S_IDLE;
                w_cnt    = C_ONE;
            end
            S_WAIT: begin
                if (!r_ks) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != S_IDLE);
        valid    = r_valid;
        err      = r_err;
        letter   = r_letter;
        sym_len  = r_len;
        sym_bits = r_bits;
    end
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: directed vector bench for morse_decoder with UNIT=4.
module tb_morse_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_in = 1'b0;
    logic       valid, err, busy;
    logic [2:0] letter, sym_len;
    logic [3:0] sym_bits;

    morse_decoder #(.UNIT(4)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .valid(valid), .err(err),
        .letter(letter), .sym_len(sym_len), .sym_bits(sym_bits), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      sym;
        int         dot;
        int         dash;
        int         gap;
        bit         ok;
        logic [2:0] let_e;
        logic [2:0] len_e;
        logic [3:0] bits_e;
    } vec_t;

    int vectors = 0, miscompares = 0;
    int cyc = 0, n_valid = 0, n_err = 0, t_valid = 0, t_err = 0;
    logic [2:0] ql[$];
    logic [3:0] qb[$];
    logic [2:0] e_let, e_len;
    logic [3:0] e_bits;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && valid) begin
            n_valid++;
            t_valid = cyc;
            ql.push_back(letter);
            qb.push_back(sym_bits);
        end
        if (rst && err) begin
            n_err++;
            t_err = cyc;
        end
        if (valid && err) begin
            vectors++;
            miscompares++;
            $display("FAIL excl: valid and err both high at cycle %0d", cyc);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        key_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input string s, input int dl, input int dh, input int gp, input int tr);
        for (int i = 0; i < s.len(); i++) begin
            hold(1'b1, (s[i] == "-") ? dh : dl);
            hold(1'b0, (i == s.len() - 1) ? tr : gp);
        end
    endtask

    task automatic clear_mon();
        n_valid = 0;
        n_err = 0;
        ql.delete();
        qb.delete();
    endtask

    vec_t tbl[8];
    string alpha[8];
    logic [3:0] alpha_bits[8];
    int t0;

    initial begin
        tbl[0] = '{".",    7, 12, 4, 1'b1, 3'd4, 3'd1, 4'b0000};
        tbl[1] = '{"-",    4,  8, 4, 1'b0, 3'd0, 3'd0, 4'b0000};
        tbl[2] = '{"..",   4, 12, 7, 1'b0, 3'd0, 3'd0, 4'b0000};
        tbl[3] = '{".....", 4, 12, 4, 1'b0, 3'd0, 3'd0, 4'b0000};
        tbl[4] = '{"-..",  7,  8, 4, 1'b1, 3'd3, 3'd3, 4'b0100};
        tbl[5] = '{"--.",  4, 12, 4, 1'b1, 3'd6, 3'd3, 4'b0110};
        tbl[6] = '{"---",  4, 12, 4, 1'b0, 3'd0, 3'd0, 4'b0000};
        tbl[7] = '{"....", 4, 12, 4, 1'b1, 3'd7, 3'd4, 4'b0000};
        alpha = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
        alpha_bits = '{4'b0001, 4'b1000, 4'b1010, 4'b0100, 4'b0000, 4'b0010, 4'b0110, 4'b0000};

        // Reset: mid-mark reset must discard everything
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        hold(1'b1, 6);
        check("busy_pre_reset", busy, 1);
        rst = 1'b0;
        #1;
        check("reset_outputs", {valid, err, letter, sym_len, sym_bits, busy}, 0);
        hold(1'b0, 3);
        rst = 1'b1;
        clear_mon();
        hold(1'b0, 20);
        check("reset_valid_cnt", n_valid, 0);
        check("reset_err_cnt", n_err, 0);
        check("reset_idle_outputs", {valid, err, letter, sym_len, sym_bits, busy}, 0);

        // Letter A with latency measurement
        clear_mon();
        hold(1'b1, 4);
        hold(1'b0, 4);
        hold(1'b1, 12);
        t0 = cyc;
        hold(1'b0, 16);
        check("A_valid_cnt", n_valid, 1);
        check("A_err_cnt", n_err, 0);
        check("A_latency", t_valid - t0, 12);
        check("A_letter", letter, 0);
        check("A_len", sym_len, 2);
        check("A_bits", sym_bits, 4'b0001);
        check("A_busy", busy, 0);

        // Alphabet with 12-cycle character gaps
        clear_mon();
        for (int i = 0; i < 8; i++) send(alpha[i], 4, 12, 4, (i == 7) ? 16 : 12);
        check("alpha_count", ql.size(), 8);
        check("alpha_err_cnt", n_err, 0);
        for (int i = 0; i < 8; i++) begin
            if (i < ql.size()) begin
                check($sformatf("alpha_letter_%0d", i), ql[i], i);
                check($sformatf("alpha_bits_%0d", i), qb[i], alpha_bits[i]);
            end
        end
        e_let = 3'd7;
        e_len = 3'd4;
        e_bits = 4'b0000;

        // Table of boundary / error / hold vectors
        for (int v = 0; v < 8; v++) begin
            clear_mon();
            send(tbl[v].sym, tbl[v].dot, tbl[v].dash, tbl[v].gap, 16);
            if (tbl[v].ok) begin
                e_let = tbl[v].let_e;
                e_len = tbl[v].len_e;
                e_bits = tbl[v].bits_e;
            end
            check($sformatf("v%0d_valid_cnt", v), n_valid, tbl[v].ok ? 1 : 0);
            check($sformatf("v%0d_err_cnt", v), n_err, tbl[v].ok ? 0 : 1);
            check($sformatf("v%0d_letter", v), letter, e_let);
            check($sformatf("v%0d_len", v), sym_len, e_len);
            check($sformatf("v%0d_bits", v), sym_bits, e_bits);
        end

        // Stuck-high line, then recovery
        clear_mon();
        t0 = cyc;
        hold(1'b1, 40);
        check("stuck_busy", busy, 1);
        hold(1'b0, 16);
        check("stuck_err_cnt", n_err, 1);
        check("stuck_valid_cnt", n_valid, 0);
        check("stuck_err_time", t_err - t0, 27);
        check("stuck_busy_after", busy, 0);
        check("stuck_letter_hold", letter, 7);
        clear_mon();
        send(".-", 4, 12, 4, 16);
        check("recover_valid_cnt", n_valid, 1);
        check("recover_err_cnt", n_err, 0);
        check("recover_letter", letter, 0);
        check("recover_bits", sym_bits, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
